// File: rtl/anita4_trig_pulse_tx_if.sv
// Handshake bundle between the L1 trigger logic and the ANITA4 trigger pulse transmitter.
// ANITA4_TRIG_TX_SCALER_EN adds the SCALER_LATCH / SENT_CNT scaler pair.
interface anita4_trig_pulse_tx_if #(
    parameter int CNT_BITS = 16
);
    logic                TRIG_REQ;
    logic                MASK;
    logic                CLR_ACK;
    logic                TRIG_OUT;
    logic                BUSY;
    logic                TIMEOUT_FLAG;
    logic [CNT_BITS-1:0] DROP_CNT;
`ifdef ANITA4_TRIG_TX_SCALER_EN
    logic                SCALER_LATCH;
    logic [CNT_BITS-1:0] SENT_CNT;

    modport master (
        output TRIG_REQ, MASK, CLR_ACK, SCALER_LATCH,
        input  TRIG_OUT, BUSY, TIMEOUT_FLAG, DROP_CNT, SENT_CNT
    );

    modport slave (
        input  TRIG_REQ, MASK, CLR_ACK, SCALER_LATCH,
        output TRIG_OUT, BUSY, TIMEOUT_FLAG, DROP_CNT, SENT_CNT
    );
`else
    modport master (
        output TRIG_REQ, MASK, CLR_ACK,
        input  TRIG_OUT, BUSY, TIMEOUT_FLAG, DROP_CNT
    );

    modport slave (
        input  TRIG_REQ, MASK, CLR_ACK,
        output TRIG_OUT, BUSY, TIMEOUT_FLAG, DROP_CNT
    );
`endif
endinterface

// File: rtl/anita4_trig_pulse_tx.sv
// ANITA4 single-pol trigger line transmitter: request -> active-low pulse -> wait clear -> holdoff.
// Optional sent-trigger scaler enabled by defining ANITA4_TRIG_TX_SCALER_EN.
module anita4_trig_pulse_tx #(
    parameter int PULSE_WIDTH    = 4,
    parameter int HOLDOFF_CYCLES = 8,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_BITS       = 16
) (
    input logic                   CLK,
    input logic                   CLR_N,
    anita4_trig_pulse_tx_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE,
        PULSE,
        WAIT_CLR,
        HOLDOFF
    } state_t;

    // One shared phase counter serves every timed state; it restarts at 0 on each state entry.
    localparam logic [15:0] PULSE_LAST   = 16'(PULSE_WIDTH - 1);
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [15:0] HOLD_LAST    = (HOLDOFF_CYCLES == 0) ? 16'd0 : 16'(HOLDOFF_CYCLES - 1);

    state_t              state;
    logic [15:0]         phase_cnt;
    logic                trig_out_q;
    logic                busy_q;
    logic                timeout_flag_q;
    logic [CNT_BITS-1:0] drop_cnt_q;
    logic                accept;

    assign accept = (state == IDLE) && bus.TRIG_REQ && !bus.MASK;

    always_ff @(posedge CLK or negedge CLR_N) begin
        if (!CLR_N) begin
            state          <= IDLE;
            phase_cnt      <= 16'd0;
            trig_out_q     <= 1'b1;
            busy_q         <= 1'b0;
            timeout_flag_q <= 1'b0;
            drop_cnt_q     <= '0;
        end else begin
            if (bus.TRIG_REQ && (state != IDLE) && (drop_cnt_q != '1)) begin
                drop_cnt_q <= drop_cnt_q + CNT_BITS'(1);
            end

            case (state)
                IDLE: begin
                    if (accept) begin
                        state      <= PULSE;
                        phase_cnt  <= 16'd0;
                        trig_out_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end

                PULSE: begin
                    if (phase_cnt == PULSE_LAST) begin
                        state      <= WAIT_CLR;
                        phase_cnt  <= 16'd0;
                        trig_out_q <= 1'b1;
                    end else begin
                        phase_cnt <= phase_cnt + 16'd1;
                    end
                end

                // A clear arriving on the terminal-count cycle wins over the timeout.
                WAIT_CLR: begin
                    if (bus.CLR_ACK) begin
                        state     <= HOLDOFF;
                        phase_cnt <= 16'd0;
                    end else if (phase_cnt == TIMEOUT_LAST) begin
                        state          <= HOLDOFF;
                        phase_cnt      <= 16'd0;
                        timeout_flag_q <= 1'b1;
                    end else begin
                        phase_cnt <= phase_cnt + 16'd1;
                    end
                end

                HOLDOFF: begin
                    if (phase_cnt == HOLD_LAST) begin
                        state     <= IDLE;
                        phase_cnt <= 16'd0;
                        busy_q    <= 1'b0;
                    end else begin
                        phase_cnt <= phase_cnt + 16'd1;
                    end
                end

                default: begin
                    state      <= IDLE;
                    phase_cnt  <= 16'd0;
                    trig_out_q <= 1'b1;
                    busy_q     <= 1'b0;
                end
            endcase
        end
    end

    assign bus.TRIG_OUT     = trig_out_q;
    assign bus.BUSY         = busy_q;
    assign bus.TIMEOUT_FLAG = timeout_flag_q;
    assign bus.DROP_CNT     = drop_cnt_q;

`ifdef ANITA4_TRIG_TX_SCALER_EN
    logic [CNT_BITS-1:0] sent_acc;
    logic [CNT_BITS-1:0] sent_cnt_q;

    // Latch snapshots the running count and restarts it; a coincident trigger counts into the new window.
    always_ff @(posedge CLK or negedge CLR_N) begin
        if (!CLR_N) begin
            sent_acc   <= '0;
            sent_cnt_q <= '0;
        end else if (bus.SCALER_LATCH) begin
            sent_cnt_q <= sent_acc;
            sent_acc   <= accept ? CNT_BITS'(1) : '0;
        end else if (accept && (sent_acc != '1)) begin
            sent_acc <= sent_acc + CNT_BITS'(1);
        end
    end

    assign bus.SENT_CNT = sent_cnt_q;
`endif

endmodule

// File: doc/anita4_trig_pulse_tx.md
Name: anita4_trig_pulse_tx

Overview:
- Transmit end of the ANITA4 single-pol trigger line.
- Turns synchronous single-cycle trigger requests from the L1 discriminator logic into a clean, registered, active-low pulse on the trigger wire.
- The far-end receiver latches on the falling edge of that wire.
- After the pulse, the block waits for the receiver-side clear (CLR_ACK), applies a holdoff, then re-arms; requests arriving while not armed are dropped and counted.

Parameters:
PULSE_WIDTH, 4, cycles TRIG_OUT is held low per trigger (valid 1..15)
HOLDOFF_CYCLES, 8, dead-time cycles after clear/timeout before re-arm (valid 0..255)
TIMEOUT_CYCLES, 255, max cycles in WAIT_CLR before giving up (valid 1..65535)
CNT_BITS, 16, width of DROP_CNT (and scaler counters when enabled)

Ports:
CLK  input  1  system clock; all logic on rising edge
CLR_N  input  1  asynchronous active-low reset
TRIG_REQ  input  1  sync single-cycle trigger request from L1 logic
MASK  input  1  1 = inhibit new triggers (sampled in IDLE only)
CLR_ACK  input  1  sync clear returned from receiver side, active-high
TRIG_OUT  output  1  trigger wire, active-low, registered, idle high
BUSY  output  1  1 whenever state != IDLE
TIMEOUT_FLAG  output  1  sticky: a WAIT_CLR timeout occurred
DROP_CNT  output  CNT_BITS  saturating count of requests dropped while BUSY

Behaviour:
- Reset (CLR_N=0, asynchronous):
  - State = IDLE.
  - TRIG_OUT=1, BUSY=0, TIMEOUT_FLAG=0, DROP_CNT=0.
  - Internal counters = 0.
- Release is synchronous to CLK; first active edge is the first rising edge with CLR_N=1.
- States: IDLE, PULSE, WAIT_CLR, HOLDOFF. All outputs are registered.
- IDLE:
  - TRIG_REQ=1 and MASK=0 at edge N → PULSE. TRIG_OUT=0 and BUSY=1 visible after edge N (latency 1 cycle).
  - TRIG_REQ=1 and MASK=1 → ignored, not counted as dropped.
- PULSE:
  - TRIG_OUT held low for exactly PULSE_WIDTH cycles.
  - On the edge ending the last low cycle: TRIG_OUT=1, go to WAIT_CLR, timeout counter=0.
  - MASK and CLR_ACK have no effect in PULSE; the pulse always completes full width.
- WAIT_CLR:
  - CLR_ACK=1 → HOLDOFF.
  - Otherwise the timeout counter increments each cycle. When it reaches TIMEOUT_CYCLES-1 with no CLR_ACK: set TIMEOUT_FLAG=1, go to HOLDOFF.
  - CLR_ACK on the same cycle as the timeout terminal count: treat as a normal clear, TIMEOUT_FLAG is not set.
- HOLDOFF:
  - Counts HOLDOFF_CYCLES cycles, then goes to IDLE.
  - HOLDOFF_CYCLES=0: exactly one cycle in HOLDOFF, then IDLE.
  - BUSY deasserts on the edge entering IDLE. A request in that first IDLE cycle is accepted.
- Dropped requests:
  - TRIG_REQ=1 in any state other than IDLE increments DROP_CNT by 1, saturating at all-ones; no wrap.
  - Applies regardless of MASK.
- Consecutive request cycles: TRIG_REQ held high for K cycles starting in IDLE (MASK=0) → one pulse, DROP_CNT += K-1.
- TIMEOUT_FLAG clears only on reset.
- Reset asserted mid-pulse: TRIG_OUT returns high immediately (asynchronous); no partial-pulse recovery.

Optional Feature:
- Macro: ANITA4_TRIG_TX_SCALER_EN.
- When defined, adds output ports SENT_CNT[CNT_BITS-1:0] and SCALER_LATCH (input, 1 bit).
  - An internal counter increments (saturating) on every IDLE→PULSE transition.
  - SCALER_LATCH=1 for one cycle copies the internal counter to SENT_CNT and clears the internal counter in the same cycle.
  - If a transition coincides with the latch, the internal counter becomes 1.
  - Latched value appears one cycle later.
  - SENT_CNT resets to 0.
- When not defined: no extra ports, no counter logic; behaviour otherwise identical.

Test Plan:
- Reset, then single TRIG_REQ pulse at cycle 10 (MASK=0, defaults) → TRIG_OUT low cycles 11-14, high at 15, BUSY=1 from 11. CLR_ACK at cycle 20 → BUSY=0 at cycle 29, DROP_CNT=0.
- TRIG_REQ with MASK=1 in IDLE → TRIG_OUT stays 1, BUSY 0, DROP_CNT 0.
- Trigger, then TRIG_REQ asserted 3 single cycles during PULSE/WAIT_CLR/HOLDOFF → exactly one low pulse, DROP_CNT=3.
- Trigger, never assert CLR_ACK, TIMEOUT_CYCLES=20 → TIMEOUT_FLAG=1 after 20 WAIT_CLR cycles, re-arm after holdoff; flag stays 1 until CLR_N=0.
- CNT_BITS=4, hold TRIG_REQ high 40 cycles with no CLR_ACK → DROP_CNT saturates at 15.
- CLR_N pulsed low mid-PULSE → TRIG_OUT=1 immediately, state IDLE; next request produces a full 4-cycle pulse.
